ex_stage: RTL and testbench
===========================

# ex_stage

Parametrised execute stage that replaces the fixed ID/EX latch plus ALU pairing. It adds valid/ready handshaking, operand forwarding muxes ahead of the stage register, synchronous flush, and an optional iterative multiply/divide unit. It sits between decode and memory: it accepts one instruction per handshake from decode and presents the result and pass-through fields to the memory stage.

## Interface
Parameters:
- WordSize, 32, datapath width (≥ 8, even)
- ModeW, 8, alu_mode width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of the held/in-flight instruction
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can capture this cycle
- branch_taken_in  in  1  pass-through
- a_sel, b_sel  in  2  operand selects (encodings below)
- imm, pc_in, rs1d, rs2d_in, branch_addr_in  in  WordSize  decode fields
- fwd_mem, fwd_wb  in  WordSize  forwarded results from the MEM and WB stages
- rdn_in  in  5  destination register
- alu_mode  in  ModeW  operation
- out_valid  out  1  result valid
- out_ready  in  1  memory stage accepts
- branch_taken  out  1
- rdn  out  5
- pc, branch_addr, rs2d, alu_out  out  WordSize
- busy  out  1  multi-cycle operation in progress

## Operation
- Operand selection before the stage register:
  - a_sel: 0 rs1d, 1 pc_in, 2 fwd_mem, 3 fwd_wb
  - b_sel: 0 rs2d_in, 1 imm, 2 fwd_mem, 3 fwd_wb
- The muxed operands a and b are registered together with all pass-through fields on capture.
- Capture occurs when in_valid && in_ready.
- in_ready = !flush && (state==EMPTY || (state==FULL && out_ready)).
- States:
  - EMPTY: capture of an ALU mode → FULL; capture of an MD mode → MD_BUSY.
  - FULL: out_valid=1. out_ready with no capture → EMPTY. out_ready with capture → FULL or MD_BUSY, following the captured mode.
  - MD_BUSY: out_valid=0, busy=1. A counter loads WordSize at capture and decrements each cycle. When the counter equals 1, the next state is FULL.
- ALU modes: alu_out is the combinational output of the existing Alu on the registered a and b.
- MD modes (signed operands handled as magnitudes, sign fixed at completion):
  - Multiply is shift-add.
  - Divide is restoring.
  - Result is registered into alu_out on the transition to FULL.
- MD corner cases (RISC-V semantics):
  - MUL returns the low word. MULH/MULHU return the high word.
  - Divide by zero: DIV/DIVU = all ones, REM/REMU = dividend.
  - Signed overflow (min ÷ −1): DIV = min, REM = 0.
- Flush has priority over everything:
  - Next state is EMPTY and any MD operation is aborted.
  - out_valid=0 next cycle.
  - No capture occurs in the flush cycle.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset values: state EMPTY; out_valid, busy, branch_taken = 0; rdn, pc, branch_addr, rs2d, alu_out, a, b = 0; MD counter = 0.
- in_ready is 0 while rst is asserted.
- ALU latency: out_valid rises the cycle after the capture edge.
- MD latency: out_valid rises WordSize cycles after the capture edge, e.g. 32 cycles for WordSize=32. busy covers exactly those cycles.
- Throughput: one ALU instruction per cycle with out_ready held high. No capture while MD_BUSY.
- Reset mid-MD: immediate return to EMPTY and the reset values.
- Flush and out_ready in the same cycle: flush wins and the held result is dropped.

## Configuration
- EX_MULDIV_EN defined: ex_muldiv is instantiated and the MD modes behave as above.
- EX_MULDIV_EN undefined:
  - No ex_muldiv and no MD_BUSY state; busy is tied to 0.
  - MD modes are treated as single-cycle ops that return 0 in FULL.

## Structure
- Package ex_pkg holds:
  - a_sel_e and b_sel_e enums
  - state_e {EMPTY, FULL, MD_BUSY}
  - MD mode constants: MUL 8'h20, MULH 8'h21, MULHU 8'h23, DIV 8'h24, DIVU 8'h25, REM 8'h26, REMU 8'h27
  - is_md() function
- Sub-module ex_muldiv(WordSize):
  - Inputs: start, mode, a, b, abort
  - Outputs: done pulse, result
  - Owns the counter and the shift datapath.
- The existing Alu is instantiated unchanged.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, all outputs 0, in_ready=0 during reset, in_ready=1 the cycle after release.
- Back-to-back ADD with stall: 3+4 then 10+5, out_ready low for 2 cycles → alu_out=7 held stable, in_ready=0 while stalled, then alu_out=15 on the next cycle.
- Forwarding: a_sel=2 with fwd_mem=100, b_sel=1 with imm=−1, ADD → alu_out=99, pc and rdn passed through.
- Multiply: MUL 7×(−6), WordSize=32 → out_valid exactly 32 cycles after capture, alu_out=−42. MULHU 0xFFFFFFFF×2 → 1.
- Divide corners:
  - DIVU 9/0 → 0xFFFFFFFF
  - REMU 9/0 → 9
  - DIV 0x80000000/−1 → 0x80000000
  - REM 0x80000000/−1 → 0
- Flush mid-DIV at cycle 10 → busy=0 and out_valid=0 next cycle, no stale result later. With EX_MULDIV_EN undefined, MUL → out_valid after 1 cycle with alu_out=0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute stage.
//   a_sel_e / b_sel_e : operand-select encodings
//   state_e           : stage occupancy (EMPTY, FULL, MD_BUSY)
//   ALU_* / MD_*      : alu_mode encodings
//   is_md()           : true for modes handled by the multiply/divide unit
package ex_pkg;

  typedef enum logic [1:0] {
    A_RS1     = 2'd0,
    A_PC      = 2'd1,
    A_FWD_MEM = 2'd2,
    A_FWD_WB  = 2'd3
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2     = 2'd0,
    B_IMM     = 2'd1,
    B_FWD_MEM = 2'd2,
    B_FWD_WB  = 2'd3
  } b_sel_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    MD_BUSY = 2'd2
  } state_e;

  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_AND  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h03;
  localparam logic [7:0] ALU_XOR  = 8'h04;
  localparam logic [7:0] ALU_SLL  = 8'h05;
  localparam logic [7:0] ALU_SRL  = 8'h06;
  localparam logic [7:0] ALU_SRA  = 8'h07;
  localparam logic [7:0] ALU_SLT  = 8'h08;
  localparam logic [7:0] ALU_SLTU = 8'h09;

  localparam logic [7:0] MD_MUL   = 8'h20;
  localparam logic [7:0] MD_MULH  = 8'h21;
  localparam logic [7:0] MD_MULHU = 8'h23;
  localparam logic [7:0] MD_DIV   = 8'h24;
  localparam logic [7:0] MD_DIVU  = 8'h25;
  localparam logic [7:0] MD_REM   = 8'h26;
  localparam logic [7:0] MD_REMU  = 8'h27;

  function automatic logic is_md(input logic [7:0] mode);
    return mode inside {MD_MUL, MD_MULH, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/alu.sv
// Alu: single-cycle combinational ALU.
//   a, b   : operands (WordSize)
//   mode   : operation (ModeW), encodings match ex_pkg::ALU_*
//   result : combinational result; unknown modes return 0
module Alu #(
  parameter int WordSize = 32,
  parameter int ModeW    = 8
) (
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [ModeW-1:0]    mode,
  output logic [WordSize-1:0] result
);

  localparam int ShW = $clog2(WordSize);

  logic [ShW-1:0] sh;
  logic signed [WordSize-1:0] a_s;
  logic signed [WordSize-1:0] b_s;

  assign sh  = b[ShW-1:0];
  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (mode)
      ModeW'(0): result = a + b;
      ModeW'(1): result = a - b;
      ModeW'(2): result = a & b;
      ModeW'(3): result = a | b;
      ModeW'(4): result = a ^ b;
      ModeW'(5): result = a << sh;
      ModeW'(6): result = a >> sh;
      ModeW'(7): result = a_s >>> sh;
      ModeW'(8): result = {{(WordSize-1){1'b0}}, (a_s < b_s)};
      ModeW'(9): result = {{(WordSize-1){1'b0}}, (a < b)};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply / divide, one bit per cycle, WordSize cycles.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load operands and begin (mode, a, b sampled this cycle)
//   mode     : one of ex_pkg::MD_* (8 bits)
//   abort    : cancel the operation in flight
//   done     : one-cycle pulse on the cycle whose edge completes the op
//   result   : valid while done is high
// Operands of signed modes are reduced to magnitudes at start; the sign is
// applied to the final step's value combinationally, so result is ready on
// the same cycle done is asserted.
module ex_muldiv import ex_pkg::*; #(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          mode,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic                abort,
  output logic                done,
  output logic [WordSize-1:0] result
);

  localparam int CntW = $clog2(WordSize + 1);

  function automatic logic [WordSize-1:0] neg_if(input logic n, input logic [WordSize-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WordSize-1:0] neg2_if(input logic n, input logic [2*WordSize-1:0] v);
    return n ? -v : v;
  endfunction

  logic [CntW-1:0]     cnt;
  logic [WordSize-1:0] hi;       // product high half / partial remainder
  logic [WordSize-1:0] lo;       // multiplier / dividend shifting into quotient
  logic [WordSize-1:0] opd;      // multiplicand / divisor magnitude
  logic [7:0]          mode_q;
  logic [WordSize-1:0] a_q;      // original dividend, returned by REM on /0
  logic                dz_q;
  logic                neg_q;    // sign of product / quotient
  logic                rneg_q;   // sign of remainder follows the dividend

  logic                sgn;
  logic signed [WordSize-1:0] a_s;
  logic signed [WordSize-1:0] b_s;
  logic                a_neg;
  logic                b_neg;

  assign sgn   = mode inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  assign a_s   = a;
  assign b_s   = b;
  assign a_neg = sgn && (a_s < 0);
  assign b_neg = sgn && (b_s < 0);

  logic                is_div;
  logic [WordSize:0]   mul_sum;
  logic [WordSize:0]   shifted;
  logic                borrow;
  logic [WordSize-1:0] hi_n;
  logic [WordSize-1:0] lo_n;

  assign is_div = mode_q[2];

  // one shift-add or restoring-divide step
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    shifted = {hi, lo[WordSize-1]};
    borrow  = shifted < {1'b0, opd};
    if (is_div) begin
      if (!borrow) begin
        hi_n = WordSize'(shifted - {1'b0, opd});
        lo_n = {lo[WordSize-2:0], 1'b1};
      end else begin
        hi_n = shifted[WordSize-1:0];
        lo_n = {lo[WordSize-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WordSize:1];
      lo_n = {mul_sum[0], lo[WordSize-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      mode_q <= '0;
      a_q    <= '0;
      dz_q   <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= CntW'(WordSize);
      hi     <= '0;
      lo     <= a_neg ? -a : a;
      opd    <= b_neg ? -b : b;
      mode_q <= mode;
      a_q    <= a;
      dz_q   <= (b == '0);
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end else if (cnt != '0) begin
      cnt <= cnt - CntW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
    end
  end

  assign done = (cnt == CntW'(1)) && !abort;

  // min / -1 needs no special case: |min| / 1 re-negates to min, remainder 0
  logic [2*WordSize-1:0] prod;
  logic [2*WordSize-1:0] prod_s;

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg2_if(neg_q, prod);

  always_comb begin
    result = '0;
    case (mode_q)
      MD_MUL:   result = prod_s[WordSize-1:0];
      MD_MULH:  result = prod_s[2*WordSize-1:WordSize];
      MD_MULHU: result = prod[2*WordSize-1:WordSize];
      MD_DIV:   result = dz_q ? '1 : neg_if(neg_q, lo_n);
      MD_DIVU:  result = dz_q ? '1 : lo_n;
      MD_REM:   result = dz_q ? a_q : neg_if(rneg_q, hi_n);
      MD_REMU:  result = dz_q ? a_q : hi_n;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with valid/ready handshake, operand forwarding,
// synchronous flush and an optional iterative multiply/divide unit.
//   Config macro: EX_MULDIV_EN -- when defined ex_muldiv is instantiated and
//   MD modes take WordSize cycles; otherwise MD modes complete in one cycle
//   with alu_out = 0 and busy is tied low.
//   Decode side : in_valid/in_ready, a_sel, b_sel, imm, pc_in, rs1d, rs2d_in,
//                 branch_addr_in, branch_taken_in, rdn_in, alu_mode,
//                 fwd_mem, fwd_wb (forwarded results)
//   Memory side : out_valid/out_ready, alu_out, pc, branch_addr, rs2d,
//                 branch_taken, rdn
//   Control     : clk, rst (async, active-high), flush (sync squash), busy
module ex_stage import ex_pkg::*; #(
  parameter int WordSize = 32,
  parameter int ModeW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                branch_taken_in,
  input  logic [1:0]          a_sel,
  input  logic [1:0]          b_sel,
  input  logic [WordSize-1:0] imm,
  input  logic [WordSize-1:0] pc_in,
  input  logic [WordSize-1:0] rs1d,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic [WordSize-1:0] fwd_mem,
  input  logic [WordSize-1:0] fwd_wb,
  input  logic [4:0]          rdn_in,
  input  logic [ModeW-1:0]    alu_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                branch_taken,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] branch_addr,
  output logic [WordSize-1:0] rs2d,
  output logic [WordSize-1:0] alu_out,
  output logic                busy
);

  // ---- stage p0: operand forwarding muxes ----
  logic [WordSize-1:0] a_p0;
  logic [WordSize-1:0] b_p0;

  always_comb begin
    a_p0 = rs1d;
    case (a_sel)
      A_RS1:     a_p0 = rs1d;
      A_PC:      a_p0 = pc_in;
      A_FWD_MEM: a_p0 = fwd_mem;
      A_FWD_WB:  a_p0 = fwd_wb;
      default:   a_p0 = rs1d;
    endcase
  end

  always_comb begin
    b_p0 = rs2d_in;
    case (b_sel)
      B_RS2:     b_p0 = rs2d_in;
      B_IMM:     b_p0 = imm;
      B_FWD_MEM: b_p0 = fwd_mem;
      B_FWD_WB:  b_p0 = fwd_wb;
      default:   b_p0 = rs2d_in;
    endcase
  end

  state_e state;
  state_e state_n;
  logic   cap;
  logic   cap_md;
  logic   md_done;

  assign in_ready = !rst && !flush && ((state == EMPTY) || ((state == FULL) && out_ready));
  assign cap      = in_valid && in_ready;

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (cap) state_n = cap_md ? MD_BUSY : FULL;
        FULL:    if (out_ready) state_n = cap ? (cap_md ? MD_BUSY : FULL) : EMPTY;
        MD_BUSY: if (md_done) state_n = FULL;
        default: state_n = EMPTY;
      endcase
    end
  end

  // ---- stage p1: stage register ----
  logic [WordSize-1:0] a_p1;
  logic [WordSize-1:0] b_p1;
  logic [ModeW-1:0]    mode_p1;
  logic                vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      a_p1         <= '0;
      b_p1         <= '0;
      mode_p1      <= '0;
      rdn          <= '0;
      pc           <= '0;
      branch_addr  <= '0;
      rs2d         <= '0;
      branch_taken <= 1'b0;
    end else begin
      state <= state_n;
      if (cap) begin
        a_p1         <= a_p0;
        b_p1         <= b_p0;
        mode_p1      <= alu_mode;
        rdn          <= rdn_in;
        pc           <= pc_in;
        branch_addr  <= branch_addr_in;
        rs2d         <= rs2d_in;
        branch_taken <= branch_taken_in;
      end
    end
  end

  assign vld_p1    = (state == FULL);
  assign out_valid = vld_p1;

  logic [WordSize-1:0] alu_res;
  logic [WordSize-1:0] md_q;
  logic                md_p1;

  Alu #(
    .WordSize (WordSize),
    .ModeW    (ModeW)
  ) u_alu (
    .a      (a_p1),
    .b      (b_p1),
    .mode   (mode_p1),
    .result (alu_res)
  );

  assign md_p1 = is_md(8'(mode_p1));

`ifdef EX_MULDIV_EN
  logic [WordSize-1:0] md_res;

  assign cap_md = cap && is_md(8'(alu_mode));

  ex_muldiv #(
    .WordSize (WordSize)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (cap_md),
    .mode   (8'(alu_mode)),
    .a      (a_p0),
    .b      (b_p0),
    .abort  (flush),
    .done   (md_done),
    .result (md_res)
  );

  // MD result lands on the same edge that moves MD_BUSY to FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_q <= '0;
    end else if (md_done && (state == MD_BUSY) && !flush) begin
      md_q <= md_res;
    end
  end

  assign busy = (state == MD_BUSY);
`else
  assign cap_md  = 1'b0;
  assign md_done = 1'b0;
  assign md_q    = '0;
  assign busy    = 1'b0;
`endif

  assign alu_out = md_p1 ? md_q : alu_res;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 32;

`ifdef EX_MULDIV_EN
  localparam int  MD_LAT  = 32;
  localparam int  MD_BUSY_CYC = 32;
  localparam bit  MD_ON   = 1'b1;
`else
  localparam int  MD_LAT  = 0;
  localparam int  MD_BUSY_CYC = 0;
  localparam bit  MD_ON   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          branch_taken_in;
  logic [1:0]    a_sel, b_sel;
  logic [W-1:0]  imm, pc_in, rs1d, rs2d_in, branch_addr_in, fwd_mem, fwd_wb;
  logic [4:0]    rdn_in;
  logic [7:0]    alu_mode;
  logic          out_valid;
  logic          out_ready;
  logic          branch_taken;
  logic [4:0]    rdn;
  logic [W-1:0]  pc, branch_addr, rs2d, alu_out;
  logic          busy;

  ex_stage #(.WordSize(W), .ModeW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .branch_taken_in(branch_taken_in),
    .a_sel(a_sel), .b_sel(b_sel),
    .imm(imm), .pc_in(pc_in), .rs1d(rs1d), .rs2d_in(rs2d_in),
    .branch_addr_in(branch_addr_in),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .rdn_in(rdn_in), .alu_mode(alu_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .branch_taken(branch_taken), .rdn(rdn), .pc(pc),
    .branch_addr(branch_addr), .rs2d(rs2d), .alu_out(alu_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] alu;
    logic [W-1:0] pcv;
    logic [W-1:0] rs2;
    logic [W-1:0] ba;
    logic [4:0]   rd;
    logic         bt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] md_exp(input logic [W-1:0] v);
    return MD_ON ? v : '0;
  endfunction

  // monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", alu_out, 'x);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("alu_out", alu_out, e.alu);
        chk("pc", pc, e.pcv);
        chk("rs2d", rs2d, e.rs2);
        chk("branch_addr", branch_addr, e.ba);
        chk("rdn", {27'd0, rdn}, {27'd0, e.rd});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
      end
    end
  end

  task automatic drive(input logic [1:0] as, input logic [1:0] bs,
                       input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [W-1:0] im, input logic [W-1:0] pcv,
                       input logic [W-1:0] fm, input logic [W-1:0] fw,
                       input logic [7:0] md, input logic [4:0] rd);
    a_sel = as; b_sel = bs; rs1d = r1; rs2d_in = r2; imm = im; pc_in = pcv;
    fwd_mem = fm; fwd_wb = fw; alu_mode = md; rdn_in = rd;
    branch_addr_in = pcv + 32'd4; branch_taken_in = rd[0];
    in_valid = 1'b1;
  endtask

  // returns #1 after the capture edge
  task automatic issue(input logic [1:0] as, input logic [1:0] bs,
                       input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [W-1:0] im, input logic [W-1:0] pcv,
                       input logic [W-1:0] fm, input logic [W-1:0] fw,
                       input logic [7:0] md, input logic [4:0] rd,
                       input logic [W-1:0] exp, input bit push);
    bit got;
    exp_t e;
    drive(as, bs, r1, r2, im, pcv, fm, fw, md, rd);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (push) begin
          e.alu = exp; e.pcv = pcv; e.rs2 = r2; e.ba = pcv + 32'd4;
          e.rd = rd; e.bt = rd[0];
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("capture_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // MD op with latency and busy-coverage measurement; out_ready must be 1
  task automatic md_op(input string nm, input logic [7:0] md,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    int k;
    int nb;
    issue(2'd0, 2'd0, a, b, 32'd0, 32'h200, 32'd0, 32'd0, md, 5'd9, md_exp(exp), 1'b1);
    k  = 0;
    nb = busy ? 1 : 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (busy) nb++;
    end
    chk({nm, "_latency"}, k, MD_LAT);
    chk({nm, "_busy_cycles"}, nb, MD_BUSY_CYC);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stale;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    drive(2'd0, 2'd0, '0, '0, '0, '0, '0, '0, 8'd0, 5'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_pc", pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // back-to-back ADD with a 2-cycle stall
    issue(2'd0, 2'd0, 32'd3, 32'd4, 32'd0, 32'h10, 32'd0, 32'd0, ALU_ADD, 5'd1, 32'd7, 1'b1);
    drive(2'd0, 2'd0, 32'd10, 32'd5, 32'd0, 32'h14, 32'd0, 32'd0, ALU_ADD, 5'd2);
    repeat (2) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_alu_out", alu_out, 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(2'd0, 2'd0, 32'd10, 32'd5, 32'd0, 32'h14, 32'd0, 32'd0, ALU_ADD, 5'd2, 32'd15, 1'b1);

    // forwarding paths, issued back to back
    issue(2'd2, 2'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h400, 32'd100, 32'd0, ALU_ADD, 5'd7, 32'd99, 1'b1);
    issue(2'd3, 2'd2, 32'd0, 32'd11, 32'd0, 32'h404, 32'd8, 32'd50, ALU_SUB, 5'd8, 32'd42, 1'b1);
    issue(2'd1, 2'd3, 32'd0, 32'd0, 32'd0, 32'h100, 32'd0, 32'h20, ALU_ADD, 5'd3, 32'h120, 1'b1);
    issue(2'd0, 2'd0, 32'hF0, 32'hFF, 32'd0, 32'h108, 32'd0, 32'd0, ALU_XOR, 5'd4, 32'h0F, 1'b1);
    @(posedge clk);
    #1;

    // multiply / divide
    md_op("mul",   MD_MUL,   32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6);
    md_op("mulhu", MD_MULHU, 32'hFFFF_FFFF,  32'd2,         32'd1);
    md_op("mulh",  MD_MULH,  32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF);
    md_op("divu0", MD_DIVU,  32'd9,          32'd0,         32'hFFFF_FFFF);
    md_op("remu0", MD_REMU,  32'd9,          32'd0,         32'd9);
    md_op("divov", MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    md_op("remov", MD_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    md_op("div",   MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    md_op("rem",   MD_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    md_op("divu",  MD_DIVU,  32'd100,        32'd7,         32'd14);
    md_op("remu",  MD_REMU,  32'd100,        32'd7,         32'd2);

    // flush mid-DIV; an instruction offered during the flush is not taken
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 32'd100, 32'd7, 32'd0, 32'h300, 32'd0, 32'd0, MD_DIV, 5'd5, 32'd0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    drive(2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'h304, 32'd0, 32'd0, ALU_ADD, 5'd6);
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("flush_no_stale", stale, 32'd0);

    // flush and out_ready together: held result is dropped
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'h500, 32'd0, 32'd0, ALU_ADD, 5'd10, 32'd2, 1'b0);
    chk("held_before_flush", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_drops_held", {31'd0, out_valid}, 32'd0);

    // reset in the middle of a MUL
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 32'd3, 32'd3, 32'd0, 32'h600, 32'd0, 32'd0, MD_MUL, 5'd11, 32'd0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_rdn", {27'd0, rdn}, 32'd0);
    chk("midrst_alu_out", alu_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // stage still works afterwards
    out_ready = 1'b1;
    issue(2'd0, 2'd1, 32'd2, 32'd0, 32'd2, 32'h700, 32'd0, 32'd0, ALU_ADD, 5'd12, 32'd4, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
